// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - multi-player reaction-time game engine
// Holdoff from an on-chip LFSR, ms prescaler, false-start/timeout detection, best-time tracking.
module reaction_timer_core #(
  parameter int NUM_PLAYERS      = 2,
  parameter int TICK_DIV         = 100000,
  parameter int DELAY_MIN_MS     = 1000,
  parameter int DELAY_RANGE_LOG2 = 11,
  parameter int TIME_W           = 12,
  localparam int WIN_W           = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] player_btn,
  output logic                   led_ready,
  output logic                   led_go,
  output logic                   false_start,
  output logic                   timeout,
  output logic [WIN_W-1:0]       winner,
  output logic [TIME_W-1:0]      reaction_ms,
  output logic [TIME_W-1:0]      best_ms,
  output logic                   round_done,
  output logic [2:0]             state
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [TIME_W-1:0] MS_LAST = {{(TIME_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_GO    = 3'd2,
    S_SCORE = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       delay_q, delay_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [TIME_W-1:0] ms_q, ms_d;
  logic [TIME_W-1:0] react_q, react_d;
  logic [TIME_W-1:0] best_q, best_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              ready_q, ready_d;
  logic              go_q, go_d;
  logic              fs_q, fs_d;
  logic              to_q, to_d;
  logic              done_q, done_d;

  logic              tick;
  logic              any_press;
  logic [WIN_W-1:0]  press_idx;
  logic [15:0]       new_delay;

  assign tick      = (presc_q == PRE_W'(TICK_DIV - 1));
  assign any_press = |player_btn;
  assign new_delay = 16'(DELAY_MIN_MS) + 16'(lfsr_q[DELAY_RANGE_LOG2-1:0]);

  always_comb begin
    press_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (player_btn[i]) press_idx = WIN_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    delay_d = delay_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    ms_d    = ms_q;
    react_d = react_q;
    best_d  = best_q;
    win_d   = win_q;
    fs_d    = fs_q;
    to_d    = to_q;

    case (state_q)
      S_IDLE: begin
        if (start_btn) begin
          state_d = S_ARMED;
          delay_d = new_delay;
        end
      end
      S_ARMED: begin
        if (tick) delay_d = delay_q - 16'd1;
        // A press always beats the final holdoff tick
        if (any_press) begin
          state_d = S_FAULT;
          win_d   = press_idx;
          fs_d    = 1'b1;
        end else if (tick && delay_q == 16'd1) begin
          state_d = S_GO;
          ms_d    = '0;
        end
      end
      S_GO: begin
        if (any_press) begin
          state_d = S_SCORE;
          win_d   = press_idx;
          react_d = ms_q;
          if (ms_q < best_q) best_d = ms_q;
        end else if (tick) begin
          if (ms_q == MS_LAST) begin
            state_d = S_SCORE;
            to_d    = 1'b1;
            react_d = '1;
          end else if (ms_q != '1) begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      S_SCORE, S_FAULT: begin
        if (start_btn) begin
          state_d = S_ARMED;
          delay_d = new_delay;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q && (state_d == S_ARMED || state_d == S_GO)) presc_d = '0;

    done_d  = (state_d != state_q) && (state_d == S_SCORE || state_d == S_FAULT);
    ready_d = (state_d == S_ARMED);
    go_d    = (state_d == S_GO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= 16'hACE1;
      delay_q <= '0;
      presc_q <= '0;
      ms_q    <= '0;
      react_q <= '0;
      best_q  <= '1;
      win_q   <= '0;
      ready_q <= 1'b0;
      go_q    <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      delay_q <= delay_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      react_q <= react_d;
      best_q  <= best_d;
      win_q   <= win_d;
      ready_q <= ready_d;
      go_q    <= go_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

  assign led_ready   = ready_q;
  assign led_go      = go_q;
  assign false_start = fs_q;
  assign timeout     = to_q;
  assign winner      = win_q;
  assign reaction_ms = react_q;
  assign best_ms     = best_q;
  assign round_done  = done_q;
  assign state       = state_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb/tb_reaction_timer_core.sv - scoreboard bench for reaction_timer_core
// Rounds are predicted from cycle arithmetic on a reference LFSR; a monitor checks each round_done.
module tb_reaction_timer_core;

  localparam int NP   = 2;
  localparam int TDIV = 4;
  localparam int DMIN = 2;
  localparam int RLOG = 2;
  localparam int TW   = 8;
  localparam int TO_CYCLES = 255 * TDIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_btn;
  logic [NP-1:0] player_btn;
  logic          led_ready, led_go, false_start, timeout, round_done;
  logic [0:0]    winner;
  logic [TW-1:0] reaction_ms, best_ms;
  logic [2:0]    state;

  reaction_timer_core #(
    .NUM_PLAYERS(NP), .TICK_DIV(TDIV), .DELAY_MIN_MS(DMIN),
    .DELAY_RANGE_LOG2(RLOG), .TIME_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .player_btn(player_btn),
    .led_ready(led_ready), .led_go(led_go), .false_start(false_start),
    .timeout(timeout), .winner(winner), .reaction_ms(reaction_ms),
    .best_ms(best_ms), .round_done(round_done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int st; int win; int react; int best; int to; int fs;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] m_lfsr;
  int   m_best, m_react, m_win;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every round_done pulse must match the next predicted round result
  always @(negedge clk) begin
    if (!rst && round_done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_round_done", 1, 0);
      end else begin
        me = q.pop_front();
        chk("done_cycle", cyc, me.cyc);
        chk("state", state, me.st);
        chk("winner", winner, me.win);
        chk("reaction_ms", reaction_ms, me.react);
        chk("best_ms", best_ms, me.best);
        chk("timeout", timeout, me.to);
        chk("false_start", false_start, me.fs);
        chk("leds_off", {led_ready, led_go}, 0);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int low_idx(input logic [1:0] pat);
    return pat[0] ? 0 : 1;
  endfunction

  // kind 0 = false start (off: edges after start, <=0 means on the final holdoff tick),
  // kind 1 = valid press (off: edges after GO entry), kind 2 = timeout
  task automatic run_round(input int kind, input logic [1:0] pat, input int off);
    int s, d, g, p, r, o;
    exp_t e;
    @(negedge clk);
    start_btn  = 1'b1;
    player_btn = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
    s = cyc + 1;
    d = DMIN + int'(m_lfsr[RLOG-1:0]);
    g = s + d * TDIV;
    @(negedge clk);
    start_btn  = 1'b0;
    player_btn = '0;
    chk("led_ready_after_start", led_ready, 1);
    chk("state_armed", state, 1);
    chk("flags_cleared", {false_start, timeout}, 0);
    if (kind == 0) begin
      o = (off <= 0) ? d * TDIV : off;
      p = s + o;
      m_win = low_idx(pat);
      e = '{p, 4, m_win, m_react, m_best, 0, 1};
    end else begin
      wait_until(g - 1);
      chk("led_go_before_holdoff", led_go, 0);
      wait_until(g);
      chk("led_go_at_holdoff", led_go, 1);
      chk("state_go", state, 2);
      if (kind == 1) begin
        p = g + off;
        r = (off - 1) / TDIV;
        m_win = low_idx(pat);
        m_react = r;
        if (r < m_best) m_best = r;
        e = '{p, 3, m_win, m_react, m_best, 0, 0};
      end else begin
        p = g + TO_CYCLES;
        m_react = 255;
        e = '{p, 3, m_win, m_react, m_best, 1, 0};
      end
    end
    q.push_back(e);
    if (kind != 2) begin
      wait_until(p - 1);
      player_btn = pat;
      @(negedge clk);
      player_btn = '0;
    end
    wait_until(p + 2);
  endtask

  task automatic power_up_start;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s, g, d;
    rst = 1'b0;
    start_btn = 1'b0;
    player_btn = '0;
    m_best = 255; m_react = 0; m_win = 0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_leds_flags", {led_ready, led_go, false_start, timeout, round_done}, 0);
    chk("rst_winner", winner, 0);
    chk("rst_reaction", reaction_ms, 0);
    chk("rst_best", best_ms, 8'hFF);
    power_up_start();

    run_round(1, 2'b10, 14);
    chk("normal_reaction", reaction_ms, 3);
    chk("normal_best", best_ms, 3);
    chk("normal_winner", winner, 1);
    run_round(0, 2'b01, 2);
    chk("fault_best_kept", best_ms, 3);
    run_round(0, 2'b10, 0);
    run_round(1, 2'b11, 9);
    chk("tie_winner", winner, 0);
    run_round(2, 2'b00, 0);
    chk("timeout_reaction", reaction_ms, 8'hFF);
    chk("timeout_best_kept", best_ms, 2);
    run_round(1, 2'b01, TO_CYCLES);
    chk("last_tick_press_valid", {timeout, reaction_ms}, {1'b0, 8'd254});

    @(negedge clk);
    start_btn = 1'b1;
    s = cyc + 1;
    d = DMIN + int'(m_lfsr[RLOG-1:0]);
    g = s + d * TDIV;
    @(negedge clk);
    start_btn = 1'b0;
    wait_until(g + 5);
    rst = 1'b1;
    #1;
    chk("midgo_rst_state", state, 0);
    chk("midgo_rst_leds", {led_ready, led_go, round_done}, 0);
    chk("midgo_rst_best", best_ms, 8'hFF);
    m_best = 255; m_react = 0; m_win = 0;
    power_up_start();
    run_round(1, 2'b10, 37);

    run_round(1, 2'b01, 4 * 5 + 1);
    chk("best_seq_5", best_ms, 5);
    run_round(1, 2'b10, 4 * 2 + 1);
    chk("best_seq_2", best_ms, 2);
    run_round(1, 2'b01, 4 * 7 + 1);
    chk("best_seq_7", best_ms, 2);

    for (int i = 0; i < 24; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 3)       run_round(0, 2'($urandom_range(1, 3)), $urandom_range(1, DMIN * TDIV));
      else if (k == 3) run_round(2, 2'b00, 0);
      else             run_round(1, 2'($urandom_range(1, 3)), $urandom_range(1, 80));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
